// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline-to-hazard-controller signal bundle
// The pipeline side drives operands and memory status; the controller answers with stall/freeze controls.
interface hazard_stall_controller_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  two_src;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_r_en;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  forward_en;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  cnt_clr;
  logic                  hazard_detected;
  logic                  pipe_freeze;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      freeze_cnt;

  modport master (
    output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
    output mem_dest, mem_wb_en, forward_en, mem_req, mem_ready, cnt_clr,
    input  hazard_detected, pipe_freeze, mem_timeout, stall_cnt, freeze_cnt
  );

  modport slave (
    input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
    input  mem_dest, mem_wb_en, forward_en, mem_req, mem_ready, cnt_clr,
    output hazard_detected, pipe_freeze, mem_timeout, stall_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - ID-stage RAW hazard detection with memory-wait freeze
// Produces bubble/freeze controls, a sticky SRAM watchdog and saturating performance counters.
module hazard_stall_controller #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;

  localparam logic [15:0]      TIMEOUT_VAL = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [15:0]           r_wait_cnt;
  logic                  r_timeout;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_freeze_cnt;

  logic [REG_ADDR_W-1:0] w_src1;
  logic [REG_ADDR_W-1:0] w_src2;
  logic [REG_ADDR_W-1:0] w_exe_dest;
  logic [REG_ADDR_W-1:0] w_mem_dest;
  logic                  w_m1e;
  logic                  w_m1m;
  logic                  w_m2e;
  logic                  w_m2m;
  logic                  w_raw_hazard;
  logic                  w_freeze_raw;
  logic                  w_pipe_freeze;
  logic                  w_hazard;
  logic                  w_wait_step;

  assign w_src1     = bus.src1;
  assign w_src2     = bus.src2;
  assign w_exe_dest = bus.exe_dest;
  assign w_mem_dest = bus.mem_dest;

  assign w_m1e = bus.exe_wb_en & (w_src1 == w_exe_dest);
  assign w_m1m = bus.mem_wb_en & (w_src1 == w_mem_dest);
  assign w_m2e = bus.two_src & bus.exe_wb_en & (w_src2 == w_exe_dest);
  assign w_m2m = bus.two_src & bus.mem_wb_en & (w_src2 == w_mem_dest);

  // With forwarding, only a load in EXE cannot be bypassed in time.
  assign w_raw_hazard = bus.forward_en ? (bus.exe_mem_r_en & (w_m1e | w_m2e))
                                       : (w_m1e | w_m1m | w_m2e | w_m2m);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:      if (bus.mem_req && !bus.mem_ready) w_next_state = ST_MEM_WAIT;
      ST_MEM_WAIT: if (bus.mem_ready) w_next_state = ST_RUN;
      default:     w_next_state = ST_RUN;
    endcase
  end

  // The held request is implied in MEM_WAIT, so mem_req is not consulted there.
  always_comb begin
    w_freeze_raw = 1'b0;
    case (r_state)
      ST_RUN:      w_freeze_raw = bus.mem_req & ~bus.mem_ready;
      ST_MEM_WAIT: w_freeze_raw = ~bus.mem_ready;
      default:     w_freeze_raw = 1'b0;
    endcase
  end

  assign w_pipe_freeze = w_freeze_raw & ~rst;
  assign w_hazard      = w_raw_hazard & ~w_pipe_freeze & ~rst;
  assign w_wait_step   = (r_state == ST_MEM_WAIT) & ~bus.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else if (w_wait_step) begin
      if (r_wait_cnt != TIMEOUT_VAL) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if ((r_wait_cnt + 16'd1) == TIMEOUT_VAL) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_wait_cnt <= 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_pipe_freeze && (r_freeze_cnt != CNT_MAX)) begin
        r_freeze_cnt <= r_freeze_cnt + CNT_ONE;
      end
    end
  end

  assign bus.hazard_detected = w_hazard;
  assign bus.pipe_freeze     = w_pipe_freeze;
  assign bus.mem_timeout     = r_timeout;
  assign bus.stall_cnt       = r_stall_cnt;
  assign bus.freeze_cnt      = r_freeze_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - bench for hazard_stall_controller
// Directed scenarios followed by random traffic, all compared against a behavioural model.
module tb_hazard_stall_controller;
  localparam int RW   = 4;
  localparam int CW   = 3;
  localparam int TO   = 4;
  localparam int CMAX = 7;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit   m_wait;
  int   m_wcnt;
  bit   m_to;
  int   m_stall;
  int   m_freeze;

  hazard_stall_controller_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  hazard_stall_controller #(.REG_ADDR_W(RW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_freeze = 0;
  endtask

  task automatic idle_inputs();
    bus.src1 = 0; bus.src2 = 0; bus.two_src = 0;
    bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
    bus.mem_dest = 0; bus.mem_wb_en = 0; bus.forward_en = 0;
    bus.mem_req = 0; bus.mem_ready = 0; bus.cnt_clr = 0;
  endtask

  // Checks one cycle against the model, then advances model and DUT across one edge.
  task automatic tick();
    bit e1, e2, m1, m2, raw, frz, hd;
    #1;
    e1  = bus.exe_wb_en && (bus.src1 == bus.exe_dest);
    m1  = bus.mem_wb_en && (bus.src1 == bus.mem_dest);
    e2  = bus.two_src && bus.exe_wb_en && (bus.src2 == bus.exe_dest);
    m2  = bus.two_src && bus.mem_wb_en && (bus.src2 == bus.mem_dest);
    raw = bus.forward_en ? (bus.exe_mem_r_en && (e1 || e2)) : (e1 || m1 || e2 || m2);
    frz = m_wait ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
    hd  = raw && !frz;
    chk("hazard_detected", 32'(bus.hazard_detected), 32'(hd));
    chk("pipe_freeze", 32'(bus.pipe_freeze), 32'(frz));
    chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    chk("freeze_cnt", 32'(bus.freeze_cnt), 32'(m_freeze));
    if (bus.cnt_clr) begin
      m_stall = 0; m_freeze = 0;
    end else begin
      m_stall  = (m_stall + int'(hd) > CMAX) ? CMAX : m_stall + int'(hd);
      m_freeze = (m_freeze + int'(frz) > CMAX) ? CMAX : m_freeze + int'(frz);
    end
    if (m_wait) begin
      if (bus.mem_ready) begin
        m_wait = 0; m_wcnt = 0;
      end else begin
        if (m_wcnt < TO) m_wcnt++;
        if (m_wcnt == TO) m_to = 1;
      end
    end else begin
      m_wcnt = 0;
      if (bus.mem_req && !bus.mem_ready) m_wait = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_exe_hit();
    bus.forward_en = 0; bus.src1 = 3; bus.exe_dest = 3; bus.exe_wb_en = 1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_exe_hit();
    bus.mem_req = 1;
    #1;
    chk("rst_hazard", 32'(bus.hazard_detected), 32'd0);
    chk("rst_freeze", 32'(bus.pipe_freeze), 32'd0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_freeze_cnt", 32'(bus.freeze_cnt), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    tick();

    set_exe_hit();
    tick();
    chk("stall_after_hit", 32'(bus.stall_cnt), 32'd1);

    idle_inputs();
    bus.forward_en = 1; bus.src2 = 5; bus.two_src = 1; bus.mem_dest = 5; bus.mem_wb_en = 1;
    #1;
    chk("fwd_mem_match", 32'(bus.hazard_detected), 32'd0);
    tick();
    bus.exe_dest = 5; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
    #1;
    chk("fwd_load_use", 32'(bus.hazard_detected), 32'd1);
    tick();
    bus.two_src = 0;
    #1;
    chk("fwd_one_src", 32'(bus.hazard_detected), 32'd0);
    tick();

    idle_inputs();
    bus.cnt_clr = 1;
    tick();
    bus.cnt_clr = 0;
    set_exe_hit();
    bus.mem_req = 1;
    repeat (3) begin
      #1;
      chk("wait_hazard_masked", 32'(bus.hazard_detected), 32'd0);
      tick();
    end
    bus.mem_ready = 1;
    #1;
    chk("ready_cycle_freeze", 32'(bus.pipe_freeze), 32'd0);
    chk("ready_cycle_hazard", 32'(bus.hazard_detected), 32'd1);
    tick();
    idle_inputs();
    chk("freeze_cnt_three", 32'(bus.freeze_cnt), 32'd3);
    tick();

    bus.mem_req = 1;
    repeat (4) tick();
    chk("timeout_not_yet", 32'(bus.mem_timeout), 32'd0);
    tick();
    chk("timeout_set", 32'(bus.mem_timeout), 32'd1);
    bus.mem_req = 0;
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    tick();
    chk("timeout_sticky", 32'(bus.mem_timeout), 32'd1);

    bus.cnt_clr = 1;
    tick();
    bus.cnt_clr = 0;
    set_exe_hit();
    repeat (10) tick();
    chk("stall_saturated", 32'(bus.stall_cnt), 32'(CMAX));
    bus.cnt_clr = 1;
    tick();
    chk("stall_cleared", 32'(bus.stall_cnt), 32'd0);
    bus.cnt_clr = 0;
    tick();
    chk("stall_resumed", 32'(bus.stall_cnt), 32'd1);

    idle_inputs();
    bus.cnt_clr = 1;
    tick();
    bus.cnt_clr = 0;
    bus.mem_req = 1;
    tick();
    bus.mem_req = 0;
    tick();
    chk("pre_rst_freeze_cnt", 32'(bus.freeze_cnt), 32'd2);
    chk("pre_rst_freeze", 32'(bus.pipe_freeze), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_freeze", 32'(bus.pipe_freeze), 32'd0);
    chk("async_freeze_cnt", 32'(bus.freeze_cnt), 32'd0);
    chk("async_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("async_timeout", 32'(bus.mem_timeout), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    tick();
    tick();

    for (int i = 0; i < 400; i++) begin
      bus.src1         = RW'($urandom_range(0, 3));
      bus.src2         = RW'($urandom_range(0, 3));
      bus.two_src      = 1'($urandom);
      bus.exe_dest     = RW'($urandom_range(0, 3));
      bus.exe_wb_en    = 1'($urandom);
      bus.exe_mem_r_en = 1'($urandom);
      bus.mem_dest     = RW'($urandom_range(0, 3));
      bus.mem_wb_en    = 1'($urandom);
      bus.forward_en   = 1'($urandom);
      bus.mem_req      = ($urandom_range(0, 3) == 0);
      bus.mem_ready    = ($urandom_range(0, 4) == 0);
      bus.cnt_clr      = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
